// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: MMIO offsets, region decode enum
// and the byte sign-extension helper.
package dmem_pkg;

  localparam logic [3:0] OFF_LED  = 4'h0;
  localparam logic [3:0] OFF_CNT  = 4'h4;
  localparam logic [3:0] OFF_CMP  = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'hC;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running counter with a compare register and a sticky match flag.
// A match seen this cycle sets the flag at the next edge; set beats a same-cycle clear.
module dmem_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic        stat_clr,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        match
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      cmp   <= '1;
      match <= 1'b0;
    end else begin
      cnt   <= cnt + 32'd1;
      if (cmp_we) cmp <= cmp_wdata;
      match <= (cnt == cmp) || (match && !stat_clr);
    end
  end

endmodule

// File: rtl/dmem_subsystem.sv
// Data-memory stage: word RAM with byte lanes, LED register and optional timer MMIO.
// Timer registers (CNT/CMP/STAT) are built only when DMEM_TIMER_EN is defined.
module dmem_subsystem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        byte_enable,
  output logic [31:0] readdata,
  output logic [7:0]  led,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  region_e           region;
  logic [AW-1:0]     widx;
  logic [1:0]        lane;
  logic [3:0]        off;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       mmio_word;
  logic [31:0]       word_rd;
  logic              ram_we;
  logic              mmio_we;
  logic              led_we;

  assign widx = addr[AW+1:2];
  assign lane = addr[1:0];
  assign off  = {addr[3:2], 2'b00};

  always_comb begin
    if (addr < RAM_BYTES)                      region = REG_RAM;
    else if (addr[31:4] == MMIO_BASE[31:4])    region = REG_MMIO;
    else                                       region = REG_UNMAPPED;
  end

  // RAM is never reset, but a store coinciding with reset must be dropped.
  assign ram_we  = memwrite && (region == REG_RAM) && !reset;
  assign mmio_we = memwrite && (region == REG_MMIO);
  assign led_we  = mmio_we && (off == OFF_LED) && (!byte_enable || lane == 2'd0);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (byte_enable) mem[widx][{lane, 3'b000} +: 8] <= writedata[7:0];
      else             mem[widx] <= writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (led_we) led <= writedata[7:0];
      if (region == REG_UNMAPPED) bus_err <= 1'b1;
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        match;
  logic        cmp_we;
  logic        stat_clr;

  assign cmp_we   = mmio_we && !byte_enable && (off == OFF_CMP);
  assign stat_clr = mmio_we && !byte_enable && (off == OFF_STAT) && writedata[0];

  dmem_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .cmp_we    (cmp_we),
    .cmp_wdata (writedata),
    .stat_clr  (stat_clr),
    .cnt       (cnt),
    .cmp       (cmp),
    .match     (match)
  );

  assign timer_irq = match;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    mmio_word = '0;
    case (off)
      OFF_LED:  mmio_word = {24'h0, led};
`ifdef DMEM_TIMER_EN
      OFF_CNT:  mmio_word = cnt;
      OFF_CMP:  mmio_word = cmp;
      OFF_STAT: mmio_word = {31'h0, match};
`endif
      default:  mmio_word = '0;
    endcase
  end

  always_comb begin
    case (region)
      REG_RAM:  word_rd = mem[widx];
      REG_MMIO: word_rd = mmio_word;
      default:  word_rd = '0;
    endcase
    readdata = byte_enable ? sext8(word_rd[{lane, 3'b000} +: 8]) : word_rd;
  end

endmodule

// File: tb/tb_dmem_subsystem.sv
// Randomized self-checking bench for dmem_subsystem against an address-map reference model.
// Timer checks are compiled when DMEM_TIMER_EN is defined.
module tb_dmem_subsystem;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        byte_enable = 1'b0;
  logic [31:0] readdata;
  logic [7:0]  led;
  logic        timer_irq;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_subsystem #(.DEPTH(64), .MMIO_BASE(MB)) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .addr        (addr),
    .writedata   (writedata),
    .byte_enable (byte_enable),
    .readdata    (readdata),
    .led         (led),
    .timer_irq   (timer_irq),
    .bus_err     (bus_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] m_ram [64];
  logic [7:0]  m_led;
  logic        m_berr;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_flag;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == MB;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic be);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    if (a < 32'd256) w = m_ram[a[7:2]];
    else if (is_mmio(a)) begin
      case (a[3:2])
        2'd0: w = {24'h0, m_led};
`ifdef DMEM_TIMER_EN
        2'd1: w = m_cnt;
        2'd2: w = m_cmp;
        2'd3: w = {31'h0, m_flag};
`endif
        default: w = '0;
      endcase
    end
    b = 8'(w >> (8 * a[1:0]));
    return be ? 32'($signed(b)) : w;
  endfunction

  task automatic model_reset();
    m_led = '0; m_berr = 1'b0; m_cnt = '0; m_cmp = '1; m_flag = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic be);
    logic [31:0] w;
    logic        clr;
    logic [31:0] old_cnt;
    logic [31:0] old_cmp;
    clr = 1'b0; old_cnt = m_cnt; old_cmp = m_cmp;
    if (a < 32'd256) begin
      if (we) begin
        w = m_ram[a[7:2]];
        if (be) w[8 * a[1:0] +: 8] = wd[7:0];
        else    w = wd;
        m_ram[a[7:2]] = w;
      end
    end else if (is_mmio(a)) begin
      if (we) begin
        case (a[3:2])
          2'd0: if (!be || a[1:0] == 2'd0) m_led = wd[7:0];
          2'd2: if (!be) m_cmp = wd;
          2'd3: if (!be) clr = wd[0];
          default: ;
        endcase
      end
    end else begin
      m_berr = 1'b1;
    end
`ifdef DMEM_TIMER_EN
    m_flag = (old_cnt == old_cmp) || (m_flag && !clr);
    m_cnt  = old_cnt + 32'd1;
`else
    m_cmp = old_cmp;
`endif
  endtask

  // Inputs are driven at the falling edge; readdata is checked 1ns later, registers after the next falling edge.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic be);
    logic [31:0] exp;
    memwrite = we; addr = a; writedata = wd; byte_enable = be;
    #1;
    last_rd = readdata;
    exp = m_read(a, be);
    if (!$isunknown(exp)) check("rd", readdata, exp);
    @(posedge clk);
    model_step(we, a, wd, be);
    @(negedge clk);
    check("led", {24'h0, led}, {24'h0, m_led});
    check("berr", {31'h0, bus_err}, {31'h0, m_berr});
`ifdef DMEM_TIMER_EN
    check("irq", {31'h0, timer_irq}, {31'h0, m_flag});
`else
    check("irq", {31'h0, timer_irq}, 32'h0);
`endif
  endtask

  task automatic do_reset(input logic we, input logic [31:0] a, input logic [31:0] wd);
    memwrite = we; addr = a; writedata = wd; byte_enable = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_led", {24'h0, led}, 32'h0);
    check("rst_berr", {31'h0, bus_err}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    memwrite = 1'b0; addr = '0; byte_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset(1'b0, '0, '0);

`ifdef DMEM_TIMER_EN
    cycle(1'b1, MB + 32'h8, 32'd5, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b0);
    check("t4_pre", {31'h0, timer_irq}, 32'h0);
    cycle(1'b0, '0, '0, 1'b0);
    check("t4_set", {31'h0, timer_irq}, 32'h1);
    cycle(1'b1, MB + 32'hC, 32'h1, 1'b0);
    check("t4_clr", {31'h0, timer_irq}, 32'h0);
    cycle(1'b1, MB + 32'h8, m_cnt + 32'd2, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b1, MB + 32'hC, 32'h1, 1'b0);
    check("t4_setwin", {31'h0, timer_irq}, 32'h1);
    dut.u_timer.cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    cycle(1'b0, MB + 32'h4, '0, 1'b0);
    cycle(1'b0, MB + 32'h4, '0, 1'b0);
    check("t5_ff", last_rd, 32'hFFFF_FFFF);
    cycle(1'b0, MB + 32'h4, '0, 1'b0);
    check("t5_wrap", last_rd, 32'h0);
`else
    cycle(1'b1, MB + 32'h8, 32'd5, 1'b0);
    cycle(1'b0, MB + 32'h4, '0, 1'b0);
    check("t5_cnt0", last_rd, 32'h0);
    cycle(1'b0, MB + 32'h8, '0, 1'b0);
    check("t5_cmp0", last_rd, 32'h0);
`endif

    for (int i = 0; i < 64; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0);

    cycle(1'b1, 32'h10, 32'h1234_5678, 1'b0);
    cycle(1'b0, 32'h10, '0, 1'b0);
    check("t1_lw", last_rd, 32'h1234_5678);
    cycle(1'b1, 32'h11, 32'hAB, 1'b1);
    cycle(1'b0, 32'h10, '0, 1'b0);
    check("t1_sb", last_rd, 32'h1234_AB78);
    cycle(1'b0, 32'h11, '0, 1'b1);
    check("t2_lbneg", last_rd, 32'hFFFF_FFAB);
    cycle(1'b0, 32'h10, '0, 1'b1);
    check("t2_lbpos", last_rd, 32'h0000_0078);
    cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    check("t2_old", last_rd, 32'h1234_AB78);
    cycle(1'b0, 32'h10, '0, 1'b0);
    check("t2_new", last_rd, 32'hDEAD_BEEF);

    cycle(1'b1, MB, 32'hA5, 1'b0);
    check("t3_led", {24'h0, led}, 32'hA5);
    cycle(1'b1, MB + 32'h1, 32'h3C, 1'b1);
    check("t3_sb1", {24'h0, led}, 32'hA5);
    cycle(1'b0, MB, '0, 1'b0);
    check("t3_lw", last_rd, 32'hA5);
    check("t6_pre", {31'h0, bus_err}, 32'h0);

    cycle(1'b0, 32'h8000_0000, '0, 1'b0);
    check("t6_rd0", last_rd, 32'h0);
    check("t6_berr", {31'h0, bus_err}, 32'h1);
    cycle(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b0, 32'h0, '0, 1'b0);
    cycle(1'b0, 32'h10, '0, 1'b0);
    check("t6_ram", last_rd, 32'hDEAD_BEEF);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      a = 32'($urandom_range(0, 63));
      else if (r < 95) a = MB + 32'($urandom_range(0, 15));
      else if (r < 98) a = 32'h100 + 32'($urandom_range(0, 255));
      else             a = 32'h8000_0000 | 32'($urandom_range(0, 4095));
      cycle(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    cycle(1'b1, MB, 32'h5A, 1'b0);
    do_reset(1'b1, 32'h10, 32'h5555_5555);
    check("t6_rled", {24'h0, led}, 32'h0);
    check("t6_rberr", {31'h0, bus_err}, 32'h0);
    cycle(1'b0, 32'h10, '0, 1'b0);
    check("t6_keep", last_rd, m_ram[4]);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'(i * 4), '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
